// File: rtl/lib_rr_pkt_mux.sv
// Round-robin packet mux: a requester keeps the shared channel from grant until its last beat is accepted.
// Optional LIB_RR_PKT_MUX_OUT_PIPE_EN inserts a 1-entry output register (1-cycle latency).
module lib_rr_pkt_mux #(
  parameter int unsigned NUM       = 4,
  parameter int unsigned NUM_BITS  = 32,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM-1:0]               in_val,
  input  logic [NUM-1:0][NUM_BITS-1:0] in_d,
  input  logic [NUM-1:0]               in_last,
  output logic [NUM-1:0]               in_rdy,
  output logic                         out_val,
  output logic [NUM_BITS-1:0]          out_d,
  output logic                         out_last,
  output logic [$clog2(NUM)-1:0]       out_id,
  input  logic                         out_rdy,
  output logic                         err_len
);
  localparam int unsigned IDW = $clog2(NUM);
  localparam int unsigned SW  = IDW + 1;
  localparam int unsigned CW  = $clog2(MAX_BEATS);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] own_q, own_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;

  logic           found_c;
  logic [IDW-1:0] srch_c;
  logic [SW-1:0]  cand_c;
  logic [IDW-1:0] gnt_c;
  logic           gnt_act_c;
  logic           gnt_val_c;
  logic           acc_rdy_c;
  logic           acc_c;

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
    return (i == IDW'(NUM - 1)) ? '0 : i + IDW'(1);
  endfunction

  // First valid requester at or after ptr_q, wrapping at NUM-1
  always_comb begin
    found_c = 1'b0;
    srch_c  = '0;
    cand_c  = '0;
    for (int unsigned k = 0; k < NUM; k++) begin
      cand_c = {1'b0, ptr_q} + SW'(k);
      if (cand_c >= SW'(NUM)) begin
        cand_c = cand_c - SW'(NUM);
      end
      if (!found_c && in_val[cand_c[IDW-1:0]]) begin
        found_c = 1'b1;
        srch_c  = cand_c[IDW-1:0];
      end
    end
  end

  // A locked owner stays connected even while its valid is low
  always_comb begin
    gnt_c     = (state_q == ST_LOCKED) ? own_q : srch_c;
    gnt_act_c = !rst && ((state_q == ST_LOCKED) || found_c);
    gnt_val_c = gnt_act_c && in_val[gnt_c];
  end

  assign acc_c = gnt_val_c && acc_rdy_c;

  always_comb begin
    in_rdy = '0;
    if (gnt_act_c) begin
      in_rdy[gnt_c] = acc_rdy_c;
    end
  end

  // Any grant that does not finish its packet this cycle becomes a lock
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (acc_c && in_last[gnt_c]) begin
      state_d = ST_IDLE;
      ptr_d   = next_idx(gnt_c);
      cnt_d   = '0;
    end else if (gnt_act_c) begin
      state_d = ST_LOCKED;
      own_d   = gnt_c;
      if (acc_c) begin
        if (cnt_q == CW'(MAX_BEATS - 1)) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign err_len = err_q;

`ifdef LIB_RR_PKT_MUX_OUT_PIPE_EN
  logic                pv_q;
  logic [NUM_BITS-1:0] pd_q;
  logic                pl_q;
  logic [IDW-1:0]      pid_q;

  assign acc_rdy_c = out_rdy || !pv_q;

  // Output slot refills on the same cycle it drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q  <= 1'b0;
      pd_q  <= '0;
      pl_q  <= 1'b0;
      pid_q <= '0;
    end else if (acc_c) begin
      pv_q  <= 1'b1;
      pd_q  <= in_d[gnt_c];
      pl_q  <= in_last[gnt_c];
      pid_q <= gnt_c;
    end else if (out_rdy) begin
      pv_q  <= 1'b0;
    end
  end

  assign out_val  = pv_q;
  assign out_d    = pd_q;
  assign out_last = pl_q;
  assign out_id   = pid_q;
`else
  assign acc_rdy_c = out_rdy;
  assign out_val   = gnt_val_c;
  assign out_d     = in_d[gnt_c];
  assign out_last  = in_last[gnt_c];
  assign out_id    = gnt_c;
`endif

endmodule
